// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable 32-bit data memory behind a valid/ready request and
// response handshake, with a configurable read latency and error detection.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32,
  parameter int READ_LAT    = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int          IDX_W    = ADDR_W - 2;
  localparam int          MEM_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] DEPTH_L  = 64'(DEPTH_WORDS);
  localparam logic [1:0]  CNT_INIT = (READ_LAT >= 2) ? 2'(READ_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [1:0]        lane_s;
  logic [IDX_W-1:0]  widx_s;
  logic [MEM_AW-1:0] mem_idx_s;
  logic              in_range_s;
  logic              bad_s;
  logic              err_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       rd_sh_s;
  logic [31:0]       load_s;
  logic [31:0]       rd_result_s;
  logic [31:0]       wr_data_s;
  logic [3:0]        wr_be_s;
  logic              accept_s;
  logic              wr_en_s;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              run_q;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       pend_rdata_q, pend_rdata_d;
  logic              pend_err_q, pend_err_d;

  always_comb begin
    lane_s     = req_addr[1:0];
    widx_s     = req_addr[ADDR_W-1:2];
    mem_idx_s  = widx_s[MEM_AW-1:0];
    in_range_s = (64'(widx_s) < DEPTH_L);
    case (req_size)
      2'b00:   bad_s = 1'b0;
      2'b01:   bad_s = req_addr[0];
      2'b10:   bad_s = (lane_s != 2'b00);
      default: bad_s = 1'b1;
    endcase
    err_s = bad_s | ~in_range_s;
  end

  // Loads shift the addressed lane down and extend; stores steer data up to the lane.
  always_comb begin
    rd_word_s = mem_q[mem_idx_s];
    rd_sh_s   = rd_word_s >> {lane_s, 3'b000};
    wr_data_s = req_wdata << {lane_s, 3'b000};
    case (req_size)
      2'b00: begin
        wr_be_s = 4'b0001 << lane_s;
        load_s  = req_unsigned ? {24'h00_0000, rd_sh_s[7:0]} : {{24{rd_sh_s[7]}}, rd_sh_s[7:0]};
      end
      2'b01: begin
        wr_be_s = 4'b0011 << lane_s;
        load_s  = req_unsigned ? {16'h0000, rd_sh_s[15:0]} : {{16{rd_sh_s[15]}}, rd_sh_s[15:0]};
      end
      2'b10: begin
        wr_be_s = 4'b1111;
        load_s  = rd_sh_s;
      end
      default: begin
        wr_be_s = 4'b0000;
        load_s  = 32'h0000_0000;
      end
    endcase
    if (err_s || req_we) begin
      rd_result_s = 32'h0000_0000;
    end else begin
      rd_result_s = load_s;
    end
  end

  // run_q blocks acceptance on the first edge after reset release.
  assign accept_s = req_valid & req_ready_q & run_q;
  assign wr_en_s  = accept_s & req_we & ~err_s;

  // rsp_valid rises one edge after RESP is entered, giving READ_LAT edges from acceptance.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          pend_rdata_d = rd_result_s;
          pend_err_d   = err_s;
          req_ready_d  = 1'b0;
          if (READ_LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pend_rdata_q;
          rsp_err_d   = pend_err_q;
        end else if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0000_0000;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 2'd0;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      run_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0000_0000;
      rsp_err_q    <= 1'b0;
      pend_rdata_q <= 32'h0000_0000;
      pend_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_q        <= 1'b1;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
    end
  end

  // Storage array: byte-lane writes, contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) begin
          mem_q[mem_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized checks of dmem_ctrl at READ_LAT 1 and 4
// against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_mem [2][4*DEPTH];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .READ_LAT(1)) u_dut_l1 (
    .CLK(clk), .RST_N(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .READ_LAT(4)) u_dut_l4 (
    .CLK(clk), .RST_N(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, access size in bytes, little-endian.
  task automatic model_req(input int d, input bit we, input logic [31:0] addr, input logic [1:0] size,
                           input bit uns, input logic [31:0] wdata,
                           output bit err, output logic [31:0] rdata);
    int unsigned a;
    int unsigned n;
    logic [31:0] v;
    a = addr;
    n = 32'd1 << size;
    v = 32'h0;
    err = (size == 2'd3) || ((a % n) != 0) || ((a / 4) >= DEPTH);
    rdata = 32'h0;
    if (!err) begin
      for (int i = 0; i < int'(n); i++) begin
        if (we) ref_mem[d][a + i] = wdata[8*i +: 8];
        else    v = v | (32'(ref_mem[d][a + i]) << (8 * i));
      end
      if (!we) begin
        if (!uns && n < 4 && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rdata = v;
      end
    end
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] addr, input logic [1:0] size,
                     input bit uns, input logic [31:0] wdata, input int hold,
                     output logic [31:0] got_rd, output logic got_err);
    bit          exp_err;
    logic [31:0] exp_rd;
    int          lat;
    string       p;
    p = $sformatf("L%0d", lat_of(d));
    check({p, "_ready_idle"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_size[d] = size; req_unsigned[d] = uns; req_wdata[d] = wdata;
    @(posedge clk); #1;
    model_req(d, we, addr, size, uns, wdata, exp_err, exp_rd);
    // Keep offering stores while busy; they must be ignored.
    req_we[d] = 1'b1; req_size[d] = 2'b10;
    req_addr[d] = 32'($urandom_range(0, DEPTH - 1)) << 2;
    req_wdata[d] = $urandom;
    check({p, "_ready_busy"}, 32'(req_ready[d]), 32'd0);
    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    check({p, "_latency"}, 32'(lat), 32'(lat_of(d)));
    got_rd  = rsp_rdata[d];
    got_err = rsp_err[d];
    check({p, "_rdata"}, got_rd, exp_rd);
    check({p, "_err"}, 32'(got_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({p, "_hold_valid"}, 32'(rsp_valid[d]), 32'd1);
      check({p, "_hold_rdata"}, rsp_rdata[d], got_rd);
      check({p, "_hold_err"}, 32'(rsp_err[d]), 32'(got_err));
      check({p, "_hold_ready"}, 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
    check({p, "_post_valid"}, 32'(rsp_valid[d]), 32'd0);
    check({p, "_post_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  task automatic reset_in_flight(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit          e;
    logic [31:0] r;
    int          pulses;
    string       p;
    p = $sformatf("L%0d", lat_of(d));
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_size[d] = 2'b10; req_unsigned[d] = 1'b0; req_wdata[d] = wdata;
    @(posedge clk); #1;
    model_req(d, we, addr, 2'b10, 1'b0, wdata, e, r);
    req_valid[d] = 1'b0;
    @(posedge clk); #1;
    rst_n[d] = 1'b0;
    #1;
    check({p, "_rif_valid"}, 32'(rsp_valid[d]), 32'd0);
    check({p, "_rif_ready"}, 32'(req_ready[d]), 32'd1);
    check({p, "_rif_rdata"}, rsp_rdata[d], 32'h0);
    check({p, "_rif_err"}, 32'(rsp_err[d]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[d] = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid[d] === 1'b1) pulses++;
    end
    check({p, "_rif_no_stale_rsp"}, 32'(pulses), 32'd0);
  endtask

  task automatic directed(input int d);
    logic [31:0] rd;
    logic        er;
    int          h;
    string       p;
    h = (d == 0) ? 0 : 5;
    p = $sformatf("L%0d", lat_of(d));
    txn(d, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, h, rd, er);
    check({p, "_st_rdata"}, rd, 32'h0);
    check({p, "_st_err"}, 32'(er), 32'd0);
    txn(d, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, h, rd, er);
    check({p, "_word_rt"}, rd, 32'hDEADBEEF);
    txn(d, 1'b1, 32'h11, 2'b00, 1'b0, 32'h0000_0080, h, rd, er);
    txn(d, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, h, rd, er);
    check({p, "_byte_merge"}, rd, 32'hDEAD80EF);
    txn(d, 1'b0, 32'h11, 2'b00, 1'b0, 32'h0, h, rd, er);
    check({p, "_sbyte"}, rd, 32'hFFFFFF80);
    txn(d, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, h, rd, er);
    check({p, "_uhalf"}, rd, 32'h0000DEAD);
    txn(d, 1'b0, 32'h13, 2'b10, 1'b0, 32'h0, h, rd, er);
    check({p, "_misalign_err"}, 32'(er), 32'd1);
    check({p, "_misalign_rdata"}, rd, 32'h0);
    txn(d, 1'b1, 32'(4 * DEPTH), 2'b10, 1'b0, 32'hCAFEF00D, h, rd, er);
    check({p, "_oor_err"}, 32'(er), 32'd1);
    txn(d, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, h, rd, er);
    check({p, "_oor_word0"}, rd, {ref_mem[d][3], ref_mem[d][2], ref_mem[d][1], ref_mem[d][0]});
    txn(d, 1'b0, 32'h20, 2'b11, 1'b0, 32'h0, h, rd, er);
    check({p, "_size11_err"}, 32'(er), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] x;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_size[d] = 2'b00; req_unsigned[d] = 1'b0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_valid", 32'(rsp_valid[d]), 32'd0);
      check("reset_rdata", rsp_rdata[d], 32'h0);
      check("reset_err", 32'(rsp_err[d]), 32'd0);
      check("reset_ready", 32'(req_ready[d]), 32'd1);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < DEPTH; w++) begin
        txn(d, 1'b1, 32'(w) << 2, 2'b10, 1'b0, $urandom, 0, rd, er);
      end
    end

    directed(0);
    directed(1);

    for (int d = 0; d < 2; d++) begin
      x = $urandom;
      reset_in_flight(d, 1'b1, 32'h18, x);
      txn(d, 1'b0, 32'h18, 2'b10, 1'b0, 32'h0, 0, rd, er);
      check("rif_store_kept", rd, x);
      reset_in_flight(d, 1'b0, 32'h18, 32'h0);
      txn(d, 1'b0, 32'h18, 2'b10, 1'b0, 32'h0, 0, rd, er);
      check("rif_after_load", rd, x);
    end

    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 150; t++) begin
        a = 32'($urandom_range(0, 4 * DEPTH + 47));
        if ($urandom_range(0, 15) == 0) a[31:24] = 8'($urandom);
        txn(d, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, int'($urandom_range(0, 2)), rd, er);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
